// File: rtl/fetch_hazard_controller.sv
// Fetch-stage and IF/ID, ID/EX pipeline-register sequencer for the 10-bit-PC core.
// Resolves branches, jumps, load-use stalls and halts, and keeps saturating perf counters.
module fetch_hazard_controller #(
   parameter int BOOT_CYCLES  = 2,
   parameter int STALL_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             branch_taken_ex,
   input  logic             jump_id,
   input  logic             jr_id,
   input  logic             ld_use_hazard,
   input  logic             halt_req,
   output logic             PCsrc,
   output logic             jump,
   output logic             jr,
   output logic             hold,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [3:0] BOOT_RELOAD  = 4'(BOOT_CYCLES - 1);
   localparam logic [2:0] STALL_RELOAD = (STALL_CYCLES > 1) ? 3'(STALL_CYCLES - 2) : 3'd0;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       r_state;
   logic [3:0]       r_bootCnt;
   logic [2:0]       r_stallCnt;
   logic [CNT_W-1:0] r_stallCount;
   logic [CNT_W-1:0] r_flushCount;

   logic w_runLike;
   logic w_branch;
   logic w_loadUse;
   logic w_jump;
   logic w_halt;

   // HALT evaluates the same priority chain as RUN, so dropping halt_req
   // releases fetch in that very cycle and the state catches up next edge.
   assign w_runLike = (r_state == ST_RUN) || (r_state == ST_HALT);
   assign w_branch  = branch_taken_ex && (r_state != ST_BOOT);
   assign w_loadUse = !w_branch && ((w_runLike && ld_use_hazard) || (r_state == ST_STALL));
   assign w_jump    = !w_branch && w_runLike && !ld_use_hazard && jump_id;
   assign w_halt    = !w_branch && w_runLike && !ld_use_hazard && !jump_id && halt_req;

   always_comb begin
      PCsrc       = 1'b0;
      jump        = 1'b0;
      jr          = 1'b0;
      hold        = 1'b0;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (rst || (r_state == ST_BOOT)) begin
         hold        = 1'b1;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (w_branch) begin
         PCsrc       = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (w_loadUse || w_halt) begin
         hold        = 1'b1;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (w_jump) begin
         jump        = 1'b1;
         jr          = jr_id;
         if_id_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_BOOT;
         r_bootCnt  <= BOOT_RELOAD;
         r_stallCnt <= 3'd0;
      end else if (r_state == ST_BOOT) begin
         if (r_bootCnt == 4'd0) begin
            r_state <= ST_RUN;
         end else begin
            r_bootCnt <= r_bootCnt - 4'd1;
         end
      end else if (w_branch) begin
         r_state <= ST_RUN;
      end else if (r_state == ST_STALL) begin
         if (r_stallCnt == 3'd0) begin
            r_state <= ST_RUN;
         end else begin
            r_stallCnt <= r_stallCnt - 3'd1;
         end
      end else if (w_loadUse) begin
         r_state    <= (STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
         r_stallCnt <= STALL_RELOAD;
      end else if (w_halt) begin
         r_state <= ST_HALT;
      end else begin
         r_state <= ST_RUN;
      end
   end

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCount <= '0;
         r_flushCount <= '0;
      end else begin
         if ((w_loadUse || w_halt) && (r_stallCount != CNT_MAX)) begin
            r_stallCount <= r_stallCount + CNT_ONE;
         end
         if ((w_branch || w_jump) && (r_flushCount != CNT_MAX)) begin
            r_flushCount <= r_flushCount + CNT_ONE;
         end
      end
   end

   assign state       = r_state;
   assign stall_count = r_stallCount;
   assign flush_count = r_flushCount;

endmodule
